// File: rtl/color_pkg.sv
// color_pkg: frame geometry, datapath widths, FSM encoding and the optional IIR helper for color_centroid.
// Rev 1.0
`default_nettype none
package color_pkg;
  localparam int H_ACTIVE = 640;
  localparam int V_ACTIVE = 480;
  localparam int CNT_W    = 19;
  localparam int SUM_W    = 29;
  localparam int Q_W      = 10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DIV  = 2'd1,
    DONE = 2'd2
  } state_e;

  // (3*old + raw) >> 2; the worst case 4*1023 still fits in 12 bits
  function automatic logic [Q_W-1:0] iir_avg(input logic [Q_W-1:0] old_v,
                                             input logic [Q_W-1:0] raw_v);
    logic [11:0] acc;
    acc = 12'(old_v) + 12'({old_v, 1'b0}) + 12'(raw_v);
    return acc[11:2];
  endfunction
endpackage
`default_nettype wire

// File: rtl/color_centroid_if.sv
// color_centroid_if: pixel stream in, per-frame centroid result out.
// Rev 1.0
`default_nettype none
interface color_centroid_if;
  import color_pkg::*;

  logic             VGA_VS;
  logic             color_detected;
  logic [9:0]       color_x;
  logic [9:0]       color_y;
  logic [Q_W-1:0]   centroid_x;
  logic [Q_W-1:0]   centroid_y;
  logic [CNT_W-1:0] pixel_count;
  logic             object_present;
  logic             centroid_valid;
  logic             frame_overrun;

  modport master (
    output VGA_VS, color_detected, color_x, color_y,
    input  centroid_x, centroid_y, pixel_count, object_present, centroid_valid, frame_overrun
  );

  modport slave (
    input  VGA_VS, color_detected, color_x, color_y,
    output centroid_x, centroid_y, pixel_count, object_present, centroid_valid, frame_overrun
  );
endinterface
`default_nettype wire

// File: rtl/seq_divider.sv
// seq_divider: restoring divider, one quotient bit per cycle MSB first; the caller guarantees the quotient fits Q_W bits.
// Rev 1.0
`default_nettype none
module seq_divider
  import color_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             start_i,
  input  logic [SUM_W-1:0] dividend_i,
  input  logic [CNT_W-1:0] divisor_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [Q_W-1:0]   quotient_o
);
  localparam int STEP_W = $clog2(Q_W);

  logic [CNT_W-1:0]  rem_q, rem_d;
  logic [Q_W-1:0]    quo_q, quo_d;
  logic [CNT_W-1:0]  dvs_q, dvs_d;
  logic [STEP_W-1:0] step_q, step_d;
  logic              busy_q, busy_d;
  logic [CNT_W:0]    shifted;
  logic [CNT_W:0]    diff;
  logic              fits;

  // quo_q starts as the low dividend bits and is shifted out as quotient bits shift in
  assign shifted = {rem_q, quo_q[Q_W-1]};
  assign diff    = shifted - {1'b0, dvs_q};
  assign fits    = shifted >= {1'b0, dvs_q};

  always_comb begin
    rem_d  = rem_q;
    quo_d  = quo_q;
    dvs_d  = dvs_q;
    step_d = step_q;
    busy_d = busy_q;
    if (start_i && !busy_q) begin
      rem_d  = dividend_i[SUM_W-1:Q_W];
      quo_d  = dividend_i[Q_W-1:0];
      dvs_d  = divisor_i;
      step_d = '0;
      busy_d = 1'b1;
    end else if (busy_q) begin
      rem_d  = fits ? diff[CNT_W-1:0] : shifted[CNT_W-1:0];
      quo_d  = {quo_q[Q_W-2:0], fits};
      step_d = step_q + STEP_W'(1);
      if (step_q == STEP_W'(Q_W - 1)) busy_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rem_q  <= '0;
      quo_q  <= '0;
      dvs_q  <= '0;
      step_q <= '0;
      busy_q <= 1'b0;
    end else begin
      rem_q  <= rem_d;
      quo_q  <= quo_d;
      dvs_q  <= dvs_d;
      step_q <= step_d;
      busy_q <= busy_d;
    end
  end

  // done marks the final iteration; the quotient is complete from the next cycle on
  assign busy_o     = busy_q;
  assign done_o     = busy_q && (step_q == STEP_W'(Q_W - 1));
  assign quotient_o = quo_q;
endmodule
`default_nettype wire

// File: rtl/color_centroid.sv
// color_centroid: per-frame colour-blob centroid; define COLOR_CENTROID_SMOOTH_EN for IIR-smoothed centroids.
// Rev 1.0
`default_nettype none
module color_centroid
  import color_pkg::*;
#(
  parameter int MIN_COUNT = 200
) (
  input  logic            clk,
  input  logic            reset,
  color_centroid_if.slave bus
);
  logic             vs_prev_q;
  logic             vs_fall;
  logic             pix_ok;
  logic [CNT_W-1:0] count_q, count_d;
  logic [SUM_W-1:0] sum_x_q, sum_x_d, sum_y_q, sum_y_d;
  logic [CNT_W-1:0] snap_cnt_q;
  state_e           state_q, state_d;
  logic             div_start, snap_load, out_load, overrun_d;
  logic             busy_x, busy_y, done_x, done_y;
  logic [Q_W-1:0]   quo_x, quo_y;
  logic [Q_W-1:0]   cx_q, cy_q, cx_d, cy_d;
  logic [CNT_W-1:0] pix_cnt_q;
  logic             present_q, present_d, valid_q, overrun_q;

  assign vs_fall = vs_prev_q & ~bus.VGA_VS;
  assign pix_ok  = bus.color_detected && (bus.color_x < 10'(H_ACTIVE)) &&
                   (bus.color_y < 10'(V_ACTIVE));

  always_comb begin
    count_d = count_q;
    sum_x_d = sum_x_q;
    sum_y_d = sum_y_q;
    if (vs_fall) begin
      count_d = '0;
      sum_x_d = '0;
      sum_y_d = '0;
    end else if (pix_ok) begin
      count_d = count_q + CNT_W'(1);
      sum_x_d = sum_x_q + SUM_W'(bus.color_x);
      sum_y_d = sum_y_q + SUM_W'(bus.color_y);
    end
  end

  always_comb begin
    state_d   = state_q;
    div_start = 1'b0;
    snap_load = 1'b0;
    out_load  = 1'b0;
    overrun_d = vs_fall && (state_q != IDLE);
    case (state_q)
      IDLE: begin
        if (vs_fall) begin
          snap_load = 1'b1;
          if (count_q == '0) begin
            state_d = DONE;
          end else begin
            state_d   = DIV;
            div_start = 1'b1;
          end
        end
      end
      DIV: begin
        if (done_x && done_y)        state_d = DONE;
        else if (!(busy_x || busy_y)) state_d = IDLE;
      end
      DONE: begin
        out_load = 1'b1;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  seq_divider u_div_x (
    .clk(clk), .reset(reset), .start_i(div_start), .dividend_i(sum_x_q),
    .divisor_i(count_q), .busy_o(busy_x), .done_o(done_x), .quotient_o(quo_x)
  );

  seq_divider u_div_y (
    .clk(clk), .reset(reset), .start_i(div_start), .dividend_i(sum_y_q),
    .divisor_i(count_q), .busy_o(busy_y), .done_o(done_y), .quotient_o(quo_y)
  );

  assign present_d = (snap_cnt_q != '0) && (snap_cnt_q >= CNT_W'(MIN_COUNT));

  // an empty frame leaves the previous centroid in place
  always_comb begin
    cx_d = cx_q;
    cy_d = cy_q;
    if (snap_cnt_q != '0) begin
`ifdef COLOR_CENTROID_SMOOTH_EN
      if (present_q && present_d) begin
        cx_d = iir_avg(cx_q, quo_x);
        cy_d = iir_avg(cy_q, quo_y);
      end else begin
        cx_d = quo_x;
        cy_d = quo_y;
      end
`else
      cx_d = quo_x;
      cy_d = quo_y;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      vs_prev_q  <= 1'b0;
      count_q    <= '0;
      sum_x_q    <= '0;
      sum_y_q    <= '0;
      snap_cnt_q <= '0;
      state_q    <= IDLE;
      cx_q       <= '0;
      cy_q       <= '0;
      pix_cnt_q  <= '0;
      present_q  <= 1'b0;
      valid_q    <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      vs_prev_q <= bus.VGA_VS;
      count_q   <= count_d;
      sum_x_q   <= sum_x_d;
      sum_y_q   <= sum_y_d;
      state_q   <= state_d;
      valid_q   <= out_load;
      overrun_q <= overrun_d;
      if (snap_load) snap_cnt_q <= count_q;
      if (out_load) begin
        cx_q      <= cx_d;
        cy_q      <= cy_d;
        pix_cnt_q <= snap_cnt_q;
        present_q <= present_d;
      end
    end
  end

  assign bus.centroid_x     = cx_q;
  assign bus.centroid_y     = cy_q;
  assign bus.pixel_count    = pix_cnt_q;
  assign bus.object_present = present_q;
  assign bus.centroid_valid = valid_q;
  assign bus.frame_overrun  = overrun_q;
endmodule
`default_nettype wire

// File: tb/tb_color_centroid.sv
// tb_color_centroid: directed frames with a scoreboard of hand-computed centroid results.
// Rev 1.0
`default_nettype none
module tb_color_centroid;
  import color_pkg::*;

  typedef struct {
    int cx;
    int cy;
    int cnt;
    int pres;
    int when;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;
  exp_t exp_q[$];
  int   ovr_q[$];
  exp_t e;
  int   ow;

  color_centroid_if bus ();

  color_centroid #(.MIN_COUNT(1)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input int req);
    total++;
    if (act !== 32'(req)) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_cx"},      32'(bus.centroid_x), 0);
    check({tag, "_cy"},      32'(bus.centroid_y), 0);
    check({tag, "_count"},   32'(bus.pixel_count), 0);
    check({tag, "_present"}, 32'(bus.object_present), 0);
    check({tag, "_valid"},   32'(bus.centroid_valid), 0);
    check({tag, "_overrun"}, 32'(bus.frame_overrun), 0);
  endtask

  // Monitor: every valid or overrun pulse must match the head of its queue
  always @(negedge clk) begin
    if (bus.centroid_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_valid: got valid at cycle %0d expected none", cyc);
      end else begin
        e = exp_q.pop_front();
        check("centroid_x",     32'(bus.centroid_x), e.cx);
        check("centroid_y",     32'(bus.centroid_y), e.cy);
        check("pixel_count",    32'(bus.pixel_count), e.cnt);
        check("object_present", 32'(bus.object_present), e.pres);
        check("valid_cycle",    32'(cyc), e.when);
      end
    end
    if (bus.frame_overrun === 1'b1) begin
      if (ovr_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_overrun: got overrun at cycle %0d expected none", cyc);
      end else begin
        ow = ovr_q.pop_front();
        check("overrun_cycle", 32'(cyc), ow);
      end
    end
  end

  task automatic push_exp(input int cx, input int cy, input int cnt, input int pres, input int when);
    exp_t x;
    x.cx = cx; x.cy = cy; x.cnt = cnt; x.pres = pres; x.when = when;
    exp_q.push_back(x);
  endtask

  task automatic pix(input int x, input int y);
    @(negedge clk);
    bus.color_detected = 1'b1;
    bus.color_x        = 10'(x);
    bus.color_y        = 10'(y);
  endtask

  task automatic quiet(input int n);
    repeat (n) begin
      @(negedge clk);
      bus.color_detected = 1'b0;
    end
  endtask

  // One-cycle VS low; pe is the cycle index whose rising edge samples the fall
  task automatic fall(input logic det, input int x, input int y, output int pe);
    @(negedge clk);
    bus.VGA_VS         = 1'b0;
    bus.color_detected = det;
    bus.color_x        = 10'(x);
    bus.color_y        = 10'(y);
    pe                 = cyc + 1;
    @(negedge clk);
    bus.VGA_VS         = 1'b1;
    bus.color_detected = 1'b0;
  endtask

  initial begin
    int p;
    int p2;
    reset              = 1'b1;
    bus.VGA_VS         = 1'b1;
    bus.color_detected = 1'b0;
    bus.color_x        = '0;
    bus.color_y        = '0;
    repeat (3) @(negedge clk);
    check_zero_outputs("reset");
    reset = 1'b0;
    quiet(3);

    // single pixel; the pixel presented on the edge cycle is dropped
    pix(100, 50);
    fall(1'b1, 600, 400, p);
    push_exp(100, 50, 1, 1, p + Q_W + 1);
    quiet(15);

    // 20x20 square: sums 123800 / 83800 over 400 pixels
    for (int y = 200; y < 220; y++)
      for (int x = 300; x < 320; x++)
        pix(x, y);
    fall(1'b0, 0, 0, p);
    push_exp(309, 209, 400, 1, p + Q_W + 1);
    quiet(15);

    // empty frame keeps the previous centroid
    fall(1'b0, 0, 0, p);
    push_exp(309, 209, 0, 0, p + 1);
    quiet(5);

    // off-screen pixels ignored
    pix(700, 10);
    pix(10, 500);
    pix(20, 30);
    fall(1'b0, 0, 0, p);
    push_exp(20, 30, 1, 1, p + Q_W + 1);
    quiet(15);

    // last visible column/row accepted, first invisible ones rejected
    pix(639, 479);
    pix(640, 5);
    pix(5, 480);
    fall(1'b0, 0, 0, p);
    push_exp(639, 479, 1, 1, p + Q_W + 1);
    quiet(15);

    // second fall 5 cycles later lands in DIV and is dropped
    pix(10, 20);
    pix(30, 60);
    fall(1'b0, 0, 0, p);
    push_exp(20, 40, 2, 1, p + Q_W + 1);
    quiet(2);
    pix(400, 400);
    fall(1'b0, 0, 0, p2);
    ovr_q.push_back(p2);
    quiet(15);

    // reset sampled at E+5 aborts the division
    pix(200, 100);
    fall(1'b0, 0, 0, p);
    while (cyc < p + 4) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check_zero_outputs("midreset");
    quiet(20);

    pix(5, 5);
    fall(1'b0, 0, 0, p);
    push_exp(5, 5, 1, 1, p + Q_W + 1);

    for (int i = 0; i < 40 && (exp_q.size() != 0 || ovr_q.size() != 0); i++)
      @(negedge clk);
    if (exp_q.size() != 0 || ovr_q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain_timeout: got %0d results and %0d overruns outstanding expected 0",
               exp_q.size(), ovr_q.size());
    end
    quiet(5);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
`default_nettype wire
